// File: rtl/bird_physics_if.sv
// Bird engine signal bundle: game-control inputs (flap, start, hit) and the
// registered bounding box / velocity / state outputs.
interface bird_physics_if #(
   parameter int N = 10,
   parameter int V = 6
);
   logic                flap;
   logic                start;
   logic                hit;
   logic [N-1:0]        x0;
   logic [N-1:0]        x1;
   logic [N-1:0]        y0;
   logic [N-1:0]        y1;
   logic signed [V-1:0] vel;
   logic                alive;
   logic                dead;

   // Game controller / key / pipe logic side.
   modport master (
      output flap, start, hit,
      input  x0, x1, y0, y1, vel, alive, dead
   );

   // Bird engine side.
   modport slave (
      input  flap, start, hit,
      output x0, x1, y0, y1, vel, alive, dead
   );
endinterface

// File: rtl/bird_physics.sv
// Bird motion engine: frame-tick divider, flap edge detect, velocity/gravity
// integration with ceiling clamp and ground death, IDLE/FLY/DEAD game state.
module bird_physics #(
   parameter int N         = 10,
   parameter int V         = 6,
   parameter int BIRD_SIZE = 15,
   parameter int SCREEN_H  = 480,
   parameter int START_X   = 160,
   parameter int START_Y   = 233,
   parameter int TICK_DIV  = 4_166_667,
   parameter int GRAVITY   = 1,
   parameter int FLAP_VEL  = 10,
   parameter int MAX_FALL  = 12
) (
   input  logic               clk,
   input  logic               reset,
   bird_physics_if.slave      bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FLY  = 2'd1,
      DEAD = 2'd2
   } state_t;

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [N-1:0] GROUND_Y = N'(SCREEN_H - BIRD_SIZE);

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                flap_q, flap_d;
   logic [N-1:0]        y0_q, y0_d;
   logic [N-1:0]        y1_q, y1_d;
   logic signed [V-1:0] vel_q, vel_d;
   logic                alive_q, alive_d;
   logic                dead_q, dead_d;

   logic                tick;
   logic                flap_edge;
   logic signed [N:0]   ny;
   int                  vel_inc;

   // Tick divider, flap edge detect and the candidate next position/velocity.
   always_comb begin
      tick      = (cnt_q == CW'(TICK_DIV - 1));
      flap_edge = bus.flap & ~flap_q;
      cnt_d     = tick ? '0 : cnt_q + CW'(1);
      flap_d    = bus.flap;
      // One extra bit so a move above the ceiling shows up as a negative value.
      ny        = $signed({1'b0, y0_q}) + $signed({{(N + 1 - V){vel_q[V-1]}}, vel_q});
      vel_inc   = int'(vel_q) + GRAVITY;
   end

   // Game state and motion update; hit outranks flap, flap outranks tick.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      state_d = state_q;
      y0_d    = y0_q;
      vel_d   = vel_q;
      case (state_q)
         IDLE: begin
            if (flap_edge) begin
               vel_d   = V'(-FLAP_VEL);
               state_d = FLY;
            end
         end
         FLY: begin
            if (bus.hit) begin
               vel_d   = '0;
               state_d = DEAD;
            end else if (flap_edge) begin
               vel_d = V'(-FLAP_VEL);
            end else if (tick) begin
               if (ny[N]) begin
                  y0_d  = '0;
                  vel_d = '0;
               end else if (ny[N-1:0] >= GROUND_Y) begin
                  y0_d    = GROUND_Y;
                  vel_d   = '0;
                  state_d = DEAD;
               end else begin
                  y0_d  = ny[N-1:0];
                  vel_d = (vel_inc > MAX_FALL) ? V'(MAX_FALL) : V'(vel_inc);
               end
            end
         end
         DEAD: begin
            if (bus.start) begin
               y0_d    = N'(START_Y);
               vel_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      y1_d    = y0_d + N'(BIRD_SIZE - 1);
      alive_d = (state_d == FLY);
      dead_d  = (state_d == DEAD);
   end

   // State, counters and registered outputs; synchronous reset to spawn.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         flap_q  <= 1'b1;
         y0_q    <= N'(START_Y);
         y1_q    <= N'(START_Y + BIRD_SIZE - 1);
         vel_q   <= '0;
         alive_q <= 1'b0;
         dead_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         flap_q  <= flap_d;
         y0_q    <= y0_d;
         y1_q    <= y1_d;
         vel_q   <= vel_d;
         alive_q <= alive_d;
         dead_q  <= dead_d;
      end
   end

   assign bus.x0    = N'(START_X);
   assign bus.x1    = N'(START_X + BIRD_SIZE - 1);
   assign bus.y0    = y0_q;
   assign bus.y1    = y1_q;
   assign bus.vel   = vel_q;
   assign bus.alive = alive_q;
   assign bus.dead  = dead_q;

endmodule

// File: tb/tb_bird_physics.sv
// Scoreboard bench for bird_physics with TICK_DIV=4: the driver pushes the
// expected post-edge state, a monitor pops and compares after each edge.
module tb_bird_physics;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   bird_physics_if #(.N(10), .V(6)) bus ();

   bird_physics #(.TICK_DIV(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      string name;
      int    y0;
      int    vel;
      bit    alive;
      bit    dead;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   e     = 0;   // index of the next edge after reset release

   // Hand-computed free fall after a flap from spawn (one entry per tick).
   int fall_y[40] = '{223, 214, 206, 199, 193, 188, 184, 181, 179, 178,
                      178, 179, 181, 184, 188, 193, 199, 206, 214, 223,
                      233, 244, 256, 268, 280, 292, 304, 316, 328, 340,
                      352, 364, 376, 388, 400, 412, 424, 436, 448, 460};
   int fall_v[40] = '{ -9,  -8,  -7,  -6,  -5,  -4,  -3,  -2,  -1,   0,
                        1,   2,   3,   4,   5,   6,   7,   8,   9,  10,
                       11,  12,  12,  12,  12,  12,  12,  12,  12,  12,
                       12,  12,  12,  12,  12,  12,  12,  12,  12,  12};

   task automatic check(input string name, input logic signed [31:0] act,
                        input logic signed [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Drive one edge's inputs at the falling edge.
   task automatic step(input bit r, input bit f, input bit s, input bit h);
      @(negedge clk);
      reset     = r;
      bus.flap  = f;
      bus.start = s;
      bus.hit   = h;
      e         = r ? 0 : e + 1;
   endtask

   task automatic push(input string n, input int y, input int v,
                       input bit a, input bit d);
      exp_t x;
      x.name  = n;
      x.y0    = y;
      x.vel   = v;
      x.alive = a;
      x.dead  = d;
      sb.push_back(x);
   endtask

   // Idle until the next driven edge has tick phase p (tick when phase 3).
   task automatic idle_to(input int p);
      while ((e % 4) != p) step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Monitor: compare one expectation just after each rising edge.
   initial begin : monitor
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            x = sb.pop_front();
            check({x.name, ".y0"},    bus.y0,    x.y0);
            check({x.name, ".y1"},    bus.y1,    x.y0 + 14);
            check({x.name, ".vel"},   bus.vel,   x.vel);
            check({x.name, ".alive"}, bus.alive, x.alive);
            check({x.name, ".dead"},  bus.dead,  x.dead);
            check({x.name, ".x0"},    bus.x0,    160);
            check({x.name, ".x1"},    bus.x1,    174);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
      $fatal(1);
   end

   initial begin : driver
      reset     = 1'b1;
      bus.flap  = 1'b1;
      bus.start = 1'b0;
      bus.hit   = 1'b0;

      // Reset with the key held, then release with the key still held.
      repeat (3) begin step(1'b1, 1'b1, 1'b0, 1'b0); push("rst", 233, 0, 0, 0); end
      repeat (3) begin step(1'b0, 1'b1, 1'b0, 1'b0); push("held", 233, 0, 0, 0); end
      repeat (40) begin step(1'b0, 1'b0, 1'b0, 1'b0); push("idle", 233, 0, 0, 0); end
      step(1'b0, 1'b0, 1'b0, 1'b1); push("idle_hit", 233, 0, 0, 0);
      step(1'b0, 1'b0, 1'b1, 1'b0); push("idle_start", 233, 0, 0, 0);

      // Flap from IDLE, then free fall to the ground.
      idle_to(0);
      step(1'b0, 1'b1, 1'b0, 1'b0); push("flap_idle", 233, -10, 1, 0);
      for (int i = 0; i < 40; i++) begin
         idle_to(3);
         step(1'b0, 1'b0, 1'b0, 1'b0); push("fall", fall_y[i], fall_v[i], 1, 0);
      end
      idle_to(3);
      step(1'b0, 1'b0, 1'b0, 1'b0); push("ground", 465, 0, 0, 1);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'(i % 2), 1'b0, 1'(i == 5)); push("ground_frozen", 465, 0, 0, 1);
      end
      step(1'b0, 1'b0, 1'b1, 1'b0); push("start_dead", 233, 0, 0, 0);
      step(1'b0, 1'b0, 1'b0, 1'b0); push("idle_after_start", 233, 0, 0, 0);

      // Flap just after every tick: climb to the ceiling and clamp at 0.
      idle_to(0);
      for (int k = 0; k < 25; k++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0);
         push("ceil_flap", (k <= 23) ? 233 - 10 * k : 0, -10, 1, 0);
         step(1'b0, 1'b0, 1'(k == 2), 1'b0);
         push("ceil_start", (k <= 23) ? 233 - 10 * k : 0, -10, 1, 0);
         step(1'b0, 1'b0, 1'b0, 1'b0);
         step(1'b0, 1'b0, 1'b0, 1'b0);
         push("ceil_tick", (k <= 22) ? 223 - 10 * k : 0, (k <= 22) ? -9 : 0, 1, 0);
      end

      // Hit while rising: freeze, then start back to spawn.
      step(1'b0, 1'b1, 1'b0, 1'b0); push("pre_hit", 0, -10, 1, 0);
      step(1'b0, 1'b0, 1'b0, 1'b1); push("hit", 0, 0, 0, 1);
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'(i % 2), 1'b0, 1'(i % 3 == 0)); push("hit_frozen", 0, 0, 0, 1);
      end
      step(1'b0, 1'b0, 1'b1, 1'b0); push("restart", 233, 0, 0, 0);

      // Flap coincident with a tick drops the tick.
      idle_to(0);
      step(1'b0, 1'b1, 1'b0, 1'b0); push("fly2", 233, -10, 1, 0);
      idle_to(3);
      step(1'b0, 1'b0, 1'b0, 1'b0); push("tick2", 223, -9, 1, 0);
      idle_to(3);
      step(1'b0, 1'b1, 1'b0, 1'b0); push("flap_tick", 223, -10, 1, 0);
      idle_to(3);
      step(1'b0, 1'b0, 1'b0, 1'b0); push("tick_after", 213, -9, 1, 0);

      // Reset mid-flight, then confirm the divider restarted from 0.
      step(1'b1, 1'b0, 1'b0, 1'b0); push("mid_reset", 233, 0, 0, 0);
      step(1'b0, 1'b0, 1'b0, 1'b0); push("post_reset", 233, 0, 0, 0);
      step(1'b0, 1'b1, 1'b0, 1'b0); push("fly3", 233, -10, 1, 0);
      step(1'b0, 1'b0, 1'b0, 1'b0); push("fly3_hold", 233, -10, 1, 0);
      step(1'b0, 1'b0, 1'b0, 1'b0); push("first_tick", 223, -9, 1, 0);

      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
      check("drain", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
